// File: rtl/speed_sensor_pkg.sv
// Shared register map, control bit positions and response codes for the speed sensor peripheral.
package speed_sensor_pkg;

    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_GATE  = 2'd1,
        REG_TOTAL = 2'd2,
        REG_SPEED = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/speed_sensor_meas.sv
// Encoder pulse measurement: input synchronizer, rising-edge detect,
// gate window counter, per-window count (SPEED), running total and irq pulse.
module speed_sensor_meas
    import speed_sensor_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sensor_in,
    input  logic        en,
    input  logic        irq_en,
    input  logic        clr,
    input  logic        restart,
    input  logic [31:0] gate,
    output logic [31:0] total,
    output logic [31:0] speed,
    output logic        irq
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic [31:0] win_cnt_q, win_cnt_d;
    logic [31:0] win_count_q, win_count_d;
    logic [31:0] total_q, total_d;
    logic [31:0] speed_q, speed_d;
    logic        irq_q, irq_d;

    logic [31:0] gate_eff;
    logic [31:0] count_inc;
    logic        rise;
    logic        win_last;

    // Next-state logic: clear beats everything, then disable, then restart/window end.
    always_comb begin
        gate_eff    = (gate < 32'd2) ? 32'd2 : gate;
        rise        = sync2_q & ~prev_q;
        win_last    = (win_cnt_q == gate_eff - 32'd1);
        count_inc   = rise ? sat_inc(win_count_q) : win_count_q;

        sync1_d     = sensor_in;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        win_cnt_d   = win_cnt_q;
        win_count_d = win_count_q;
        total_d     = total_q;
        speed_d     = speed_q;
        irq_d       = 1'b0;

        if (clr) begin
            total_d     = 32'd0;
            speed_d     = 32'd0;
            win_count_d = 32'd0;
            win_cnt_d   = 32'd0;
        end else if (!en) begin
            win_cnt_d   = 32'd0;
            win_count_d = 32'd0;
        end else begin
            if (rise) begin
                total_d = total_q + 32'd1;
            end
            if (restart) begin
                win_cnt_d   = 32'd0;
                win_count_d = 32'd0;
            end else if (win_last) begin
                speed_d     = count_inc;
                win_cnt_d   = 32'd0;
                win_count_d = 32'd0;
                irq_d       = irq_en;
            end else begin
                win_cnt_d   = win_cnt_q + 32'd1;
                win_count_d = count_inc;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            win_cnt_q   <= 32'd0;
            win_count_q <= 32'd0;
            total_q     <= 32'd0;
            speed_q     <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            win_cnt_q   <= win_cnt_d;
            win_count_q <= win_count_d;
            total_q     <= total_d;
            speed_q     <= speed_d;
            irq_q       <= irq_d;
        end
    end

    assign total = total_q;
    assign speed = speed_q;
    assign irq   = irq_q;

endmodule

// File: rtl/speed_sensor_axi_slave.sv
// AXI4-Lite front end for the speed sensor: single-outstanding write and read
// handshakes, CTRL/GATE registers, and the measurement block behind them.
module speed_sensor_axi_slave
    import speed_sensor_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] DEFAULT_GATE = 32'd100000000
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [3:0]                      s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic                            sensor_in,
    output logic                            irq
);

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] gate_q, gate_d;

    logic        wr_fire, rd_fire;
    reg_sel_e    wr_sel, rd_sel;
    logic [31:0] gate_wr;
    logic        clr_pulse, restart_pulse;
    logic [31:0] total, speed;
    logic        unused_inputs;

    assign wr_fire = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_fire = arready_q & s00_axi_arvalid;
    assign wr_sel  = reg_sel_e'(s00_axi_awaddr[3:2]);
    assign rd_sel  = reg_sel_e'(s00_axi_araddr[3:2]);

    // Byte-lane merge of write data into GATE under wstrb.
    for (genvar gi = 0; gi < 4; gi++) begin : g_gate_lane
        assign gate_wr[gi*8 +: 8] = s00_axi_wstrb[gi] ? s00_axi_wdata[gi*8 +: 8] : gate_q[gi*8 +: 8];
    end

    // Handshake sequencing and register write/read decode.
    always_comb begin
        awready_d     = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
        arready_d     = s00_axi_arvalid & ~rvalid_q & ~arready_q;
        bvalid_d      = bvalid_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        ctrl_d        = ctrl_q;
        gate_d        = gate_q;
        clr_pulse     = 1'b0;
        restart_pulse = 1'b0;

        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (wr_fire) begin
            case (wr_sel)
                REG_CTRL: begin
                    if (s00_axi_wstrb[0]) begin
                        ctrl_d[CTRL_EN]     = s00_axi_wdata[CTRL_EN];
                        ctrl_d[CTRL_IRQ_EN] = s00_axi_wdata[CTRL_IRQ_EN];
                        clr_pulse           = s00_axi_wdata[CTRL_CLR];
                    end
                end
                REG_GATE: begin
                    gate_d        = gate_wr;
                    restart_pulse = 1'b1;
                end
                default: ;
            endcase
        end

        if (rd_fire) begin
            rvalid_d = 1'b1;
            case (rd_sel)
                REG_CTRL:  rdata_d = ctrl_q;
                REG_GATE:  rdata_d = gate_q;
                REG_TOTAL: rdata_d = total;
                REG_SPEED: rdata_d = speed;
                default:   rdata_d = 32'd0;
            endcase
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Interface and register state; reset drops any transaction in flight.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            ctrl_q    <= 32'd0;
            gate_q    <= DEFAULT_GATE;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            gate_q    <= gate_d;
        end
    end

    speed_sensor_meas u_meas (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .sensor_in (sensor_in),
        .en        (ctrl_q[CTRL_EN]),
        .irq_en    (ctrl_q[CTRL_IRQ_EN]),
        .clr       (clr_pulse),
        .restart   (restart_pulse),
        .gate      (gate_q),
        .total     (total),
        .speed     (speed),
        .irq       (irq)
    );

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;

    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule
